// File: rtl/ft245_rx_packetizer.sv
// Receive-side packetizer behind the FT245 sync-to-AXIS converter: a skid-headroom FIFO,
// a hold register that frames beats with tlast on idle timeout or on the maximum packet length.
module ft245_rx_packetizer #(
    parameter int bus_width    = 1,
    parameter int fifo_depth   = 16,
    parameter int skid_depth   = 4,
    parameter int idle_timeout = 8,
    parameter int max_packet   = 256
) (
    input  logic                   aclk,
    input  logic                   arstn,
    input  logic [bus_width*8-1:0] s_axis_tdata,
    input  logic [bus_width-1:0]   s_axis_tkeep,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    output logic [bus_width*8-1:0] m_axis_tdata,
    output logic [bus_width-1:0]   m_axis_tkeep,
    output logic                   m_axis_tvalid,
    output logic                   m_axis_tlast,
    input  logic                   m_axis_tready,
    output logic                   overflow
);

    localparam int dw = bus_width * 8;
    localparam int ew = dw + bus_width;
    localparam int aw = $clog2(fifo_depth);
    localparam int iw = $clog2(idle_timeout + 1);
    localparam int bw = $clog2(max_packet + 1);

    localparam logic [aw:0]   depth_c     = (aw + 1)'(fifo_depth);
    localparam logic [aw:0]   ready_thr   = (aw + 1)'(fifo_depth - skid_depth);
    localparam logic [iw-1:0] idle_max    = iw'(idle_timeout);
    localparam logic [bw-1:0] last_beat_c = bw'(max_packet - 1);

    // st_wait: beat held, not yet offered; st_out: offered and stalled, so outputs are frozen.
    typedef enum logic [1:0] {
        st_empty,
        st_wait,
        st_out
    } hold_state_t;

    hold_state_t state_q, state_d;

    logic [ew-1:0] mem [fifo_depth];
    logic [aw-1:0] wr_ptr, rd_ptr;
    logic [aw:0]   count;
    logic [iw-1:0] idle_cnt;
    logic [bw-1:0] beat_cnt;
    logic [dw-1:0] h_data;
    logic [bus_width-1:0] h_keep;
    logic          last_q;

    logic fifo_empty, fifo_full, in_beat, wr_en, h_load, handshake, last_cond;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == depth_c);
    assign in_beat    = s_axis_tvalid && (s_axis_tkeep != '0);
    assign handshake  = m_axis_tvalid && m_axis_tready;
    assign h_load     = !fifo_empty && ((state_q == st_empty) || handshake);
    // A full FIFO still takes a beat when the head leaves on the same edge.
    assign wr_en      = in_beat && (!fifo_full || h_load);
    assign last_cond  = (idle_cnt == idle_max) || (beat_cnt == last_beat_c);

    assign m_axis_tvalid = (state_q == st_out) ||
                           ((state_q == st_wait) && (!fifo_empty || last_cond));
    assign m_axis_tlast  = (state_q == st_out) ? last_q : ((state_q == st_wait) && last_cond);
    assign m_axis_tdata  = h_data;
    assign m_axis_tkeep  = h_keep;

    // NOTE: storage array has no reset; only pointers and count need it, which keeps it RAM-mappable.
    always_ff @(posedge aclk) begin
        if (wr_en) mem[wr_ptr] <= {s_axis_tkeep, s_axis_tdata};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            s_axis_tready <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            if (wr_en)  wr_ptr <= wr_ptr + aw'(1);
            if (h_load) rd_ptr <= rd_ptr + aw'(1);
            case ({wr_en, h_load})
                2'b10:   count <= count + (aw + 1)'(1);
                2'b01:   count <= count - (aw + 1)'(1);
                default: count <= count;
            endcase
            s_axis_tready <= (count < ready_thr);
            if (in_beat && !wr_en) overflow <= 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            idle_cnt <= '0;
            beat_cnt <= '0;
            h_data   <= '0;
            h_keep   <= '0;
            last_q   <= 1'b0;
        end else begin
            if (wr_en) begin
                idle_cnt <= '0;
            end else if ((state_q != st_empty) && fifo_empty && (idle_cnt != idle_max)) begin
                idle_cnt <= idle_cnt + iw'(1);
            end
            if (handshake) beat_cnt <= m_axis_tlast ? '0 : beat_cnt + bw'(1);
            if (h_load) {h_keep, h_data} <= mem[rd_ptr];
            if (m_axis_tvalid && !m_axis_tready) last_q <= m_axis_tlast;
        end
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) state_q <= st_empty;
        else        state_q <= state_d;
    end

    // NOTE: state_d gets its default first so no path through the case leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            st_empty: if (!fifo_empty) state_d = st_wait;
            st_wait, st_out: begin
                if (m_axis_tvalid) begin
                    if (m_axis_tready) state_d = fifo_empty ? st_empty : st_wait;
                    else               state_d = st_out;
                end
            end
            default: state_d = st_empty;
        endcase
    end

endmodule

// File: tb/tb_ft245_rx_packetizer.sv
// Bench for ft245_rx_packetizer: two instances (max_packet 256 and 4) share stimulus and are
// compared every cycle against a queue-based model, plus hand-computed directed expectations.
module tb_ft245_rx_packetizer;

    localparam int DEPTH = 16;
    localparam int SKID  = 4;
    localparam int IT    = 8;

    typedef struct packed {
        logic [7:0] data;
        logic       keep;
        logic       last;
    } beat_t;

    logic       aclk = 1'b0;
    logic       arstn = 1'b0;
    logic [7:0] s_tdata = '0;
    logic       s_tkeep = 1'b0;
    logic       s_tvalid = 1'b0;
    logic       m_tready = 1'b0;

    logic       o_sready [2];
    logic [7:0] o_tdata  [2];
    logic       o_tkeep  [2];
    logic       o_tvalid [2];
    logic       o_tlast  [2];
    logic       o_ovf    [2];

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always #5 aclk = ~aclk;

    ft245_rx_packetizer #(.bus_width(1), .fifo_depth(DEPTH), .skid_depth(SKID),
                          .idle_timeout(IT), .max_packet(256)) dut0 (
        .aclk(aclk), .arstn(arstn),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(o_sready[0]),
        .m_axis_tdata(o_tdata[0]), .m_axis_tkeep(o_tkeep[0]), .m_axis_tvalid(o_tvalid[0]),
        .m_axis_tlast(o_tlast[0]), .m_axis_tready(m_tready), .overflow(o_ovf[0])
    );

    ft245_rx_packetizer #(.bus_width(1), .fifo_depth(DEPTH), .skid_depth(SKID),
                          .idle_timeout(IT), .max_packet(4)) dut1 (
        .aclk(aclk), .arstn(arstn),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(o_sready[1]),
        .m_axis_tdata(o_tdata[1]), .m_axis_tkeep(o_tkeep[1]), .m_axis_tvalid(o_tvalid[1]),
        .m_axis_tlast(o_tlast[1]), .m_axis_tready(m_tready), .overflow(o_ovf[1])
    );

    // ---------------- behavioural model ----------------
    beat_t m_q     [2][$];
    beat_t out_log [2][$];
    beat_t m_h     [2];
    logic  m_hv    [2];
    logic  m_rel   [2];
    logic  m_last  [2];
    logic  m_ovf   [2];
    logic  m_rdy   [2];
    int    m_idle  [2];
    int    m_bc    [2];

    function automatic int mp_of(input int i);
        return (i == 0) ? 256 : 4;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_q[i].delete();
            m_h[i]    = '0;
            m_hv[i]   = 1'b0;
            m_rel[i]  = 1'b0;
            m_last[i] = 1'b0;
            m_ovf[i]  = 1'b0;
            m_rdy[i]  = 1'b0;
            m_idle[i] = 0;
            m_bc[i]   = 0;
        end
    endtask

    task automatic clear_logs();
        for (int i = 0; i < 2; i++) out_log[i].delete();
    endtask

    // Release rule: a held beat goes out once a successor exists, the idle timeout expires,
    // or it would be the final beat of a maximum-length packet; tlast is fixed at that moment.
    task automatic model_release(input int i);
        bit at_limit;
        at_limit = (m_idle[i] == IT) || (m_bc[i] == mp_of(i) - 1);
        if (m_hv[i] && !m_rel[i] && (m_q[i].size() > 0 || at_limit)) begin
            m_rel[i]  = 1'b1;
            m_last[i] = at_limit;
        end
    endtask

    task automatic model_step(input int i);
        bit    hs, pop, req, push;
        int    n;
        beat_t b;
        n    = m_q[i].size();
        hs   = m_rel[i] && m_tready;
        pop  = (n > 0) && (!m_hv[i] || hs);
        req  = s_tvalid && s_tkeep;
        push = req && ((n - int'(pop)) < DEPTH);
        if (req && !push) m_ovf[i] = 1'b1;
        m_rdy[i] = (n < DEPTH - SKID);
        if (push) m_idle[i] = 0;
        else if (m_hv[i] && n == 0 && m_idle[i] < IT) m_idle[i]++;
        if (hs) begin
            b      = m_h[i];
            b.last = m_last[i];
            out_log[i].push_back(b);
            m_bc[i]  = m_last[i] ? 0 : m_bc[i] + 1;
            m_rel[i] = 1'b0;
        end
        if (pop) begin
            m_h[i]  = m_q[i].pop_front();
            m_hv[i] = 1'b1;
        end else if (hs) begin
            m_hv[i] = 1'b0;
        end
        if (push) begin
            b.data = s_tdata;
            b.keep = s_tkeep;
            b.last = 1'b0;
            m_q[i].push_back(b);
        end
        model_release(i);
    endtask

    always @(posedge aclk) cyc <= cyc + 1;

    always @(posedge aclk) begin
        if (arstn) begin
            for (int i = 0; i < 2; i++) model_step(i);
        end
    end

    always @(negedge arstn) model_reset();

    // Every-cycle comparison of both instances against the model.
    always @(negedge aclk) begin
        for (int i = 0; i < 2; i++) begin
            check($sformatf("i%0d tvalid", i), 32'(o_tvalid[i]), 32'(m_rel[i]));
            if (m_rel[i]) begin
                check($sformatf("i%0d tdata", i), 32'(o_tdata[i]), 32'(m_h[i].data));
                check($sformatf("i%0d tkeep", i), 32'(o_tkeep[i]), 32'(m_h[i].keep));
                check($sformatf("i%0d tlast", i), 32'(o_tlast[i]), 32'(m_last[i]));
            end
            check($sformatf("i%0d s_tready", i), 32'(o_sready[i]), 32'(m_rdy[i]));
            check($sformatf("i%0d overflow", i), 32'(o_ovf[i]), 32'(m_ovf[i]));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [7:0] d, input logic k, output int t);
        s_tdata  = d;
        s_tkeep  = k;
        s_tvalid = 1'b1;
        @(posedge aclk);
        #1;
        t        = cyc;
        s_tvalid = 1'b0;
        s_tkeep  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic wait_valid(input int i, input logic [7:0] d, input int limit,
                              output int t, output bit ok);
        ok = 1'b0;
        t  = 0;
        for (int c = 0; c < limit && !ok; c++) begin
            @(negedge aclk);
            if (o_tvalid[i] && o_tdata[i] == d) begin
                ok = 1'b1;
                t  = cyc;
            end
        end
        if (!ok) check($sformatf("i%0d wait for %0h timed out", i, d), 32'(0), 32'(1));
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s i%0d s_tready", tag, i), 32'(o_sready[i]), 32'(0));
            check($sformatf("%s i%0d tvalid", tag, i), 32'(o_tvalid[i]), 32'(0));
            check($sformatf("%s i%0d tlast", tag, i), 32'(o_tlast[i]), 32'(0));
            check($sformatf("%s i%0d tdata", tag, i), 32'(o_tdata[i]), 32'(0));
            check($sformatf("%s i%0d tkeep", tag, i), 32'(o_tkeep[i]), 32'(0));
            check($sformatf("%s i%0d overflow", tag, i), 32'(o_ovf[i]), 32'(0));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  tw, t, n51;
        bit  ok;
        model_reset();

        // Reset state
        #2;
        check_all_zero("reset");
        repeat (2) @(posedge aclk);
        #3 arstn = 1'b1;
        @(posedge aclk);
        #1;
        check("ready after reset", 32'(o_sready[0]), 32'(1));
        m_tready = 1'b1;

        // Single beat, released 8 cycles after it reaches the hold register
        clear_logs();
        send(8'hA5, 1'b1, tw);
        wait_valid(0, 8'hA5, 40, t, ok);
        check("t1 latency from hold", 32'(t - (tw + 1)), 32'(8));
        check("t1 tlast", 32'(o_tlast[0]), 32'(1));
        check("t1 overflow", 32'(o_ovf[0]), 32'(0));
        idle(3);
        check("t1 beats", 32'(out_log[0].size()), 32'(1));
        if (out_log[0].size() == 1)
            check("t1 logged beat", 32'(out_log[0][0]), 32'({8'hA5, 1'b1, 1'b1}));

        // Burst of five, last one closed by timeout
        clear_logs();
        for (int k = 1; k <= 5; k++) send(8'(k), 1'b1, tw);
        idle(20);
        check("t2 beats i0", 32'(out_log[0].size()), 32'(5));
        check("t2 beats i1", 32'(out_log[1].size()), 32'(5));
        for (int k = 0; k < 5 && k < out_log[0].size() && k < out_log[1].size(); k++) begin
            check($sformatf("t2 i0 beat%0d", k), 32'(out_log[0][k]),
                  32'({8'(k + 1), 1'b1, (k == 4) ? 1'b1 : 1'b0}));
            check($sformatf("t2 i1 beat%0d", k), 32'(out_log[1][k]),
                  32'({8'(k + 1), 1'b1, (k >= 3) ? 1'b1 : 1'b0}));
        end

        // Downstream stall: ready drops at count 12, headroom takes 4 more, the next is lost
        m_tready = 1'b0;
        clear_logs();
        for (int k = 0; k < 13; k++) send(8'h40 + 8'(k), 1'b1, tw);
        check("t3 ready lags count", 32'(o_sready[0]), 32'(1));
        for (int k = 13; k < 17; k++) send(8'h40 + 8'(k), 1'b1, tw);
        check("t3 ready low", 32'(o_sready[0]), 32'(0));
        check("t3 no overflow yet", 32'(o_ovf[0]), 32'(0));
        send(8'h51, 1'b1, tw);
        check("t3 overflow i0", 32'(o_ovf[0]), 32'(1));
        check("t3 overflow i1", 32'(o_ovf[1]), 32'(1));
        m_tready = 1'b1;
        idle(60);
        check("t3 drained i0", 32'(out_log[0].size()), 32'(17));
        check("t3 drained i1", 32'(out_log[1].size()), 32'(17));
        if (out_log[0].size() == 17)
            check("t3 final beat", 32'(out_log[0][16]), 32'({8'h50, 1'b1, 1'b1}));
        n51 = 0;
        foreach (out_log[0][k]) if (out_log[0][k].data == 8'h51) n51++;
        check("t3 dropped beat absent", 32'(n51), 32'(0));

        // max_packet=4 instance: tlast on beats 4, 8 and (timeout) 10
        clear_logs();
        for (int k = 1; k <= 10; k++) send(8'h80 + 8'(k), 1'b1, tw);
        idle(30);
        check("t4 beats i1", 32'(out_log[1].size()), 32'(10));
        check("t4 beats i0", 32'(out_log[0].size()), 32'(10));
        for (int k = 0; k < 10 && k < out_log[1].size() && k < out_log[0].size(); k++) begin
            check($sformatf("t4 i1 last%0d", k + 1), 32'(out_log[1][k].last),
                  32'((k == 3 || k == 7 || k == 9) ? 1 : 0));
            check($sformatf("t4 i0 last%0d", k + 1), 32'(out_log[0][k].last),
                  32'((k == 9) ? 1 : 0));
        end

        // Zero-keep beats are dropped and do not restart the idle timer
        clear_logs();
        send(8'h11, 1'b1, tw);
        send(8'hEE, 1'b0, tw);
        send(8'hEE, 1'b0, tw);
        send(8'h22, 1'b1, tw);
        s_tdata  = 8'hEE;
        s_tkeep  = 1'b0;
        s_tvalid = 1'b1;
        wait_valid(0, 8'h22, 40, t, ok);
        check("t5 timeout despite zero-keep", 32'(t - tw), 32'(9));
        check("t5 tlast", 32'(o_tlast[0]), 32'(1));
        @(posedge aclk);
        #1;
        s_tvalid = 1'b0;
        idle(5);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("t5 i%0d beats", i), 32'(out_log[i].size()), 32'(2));
            if (out_log[i].size() == 2) begin
                check($sformatf("t5 i%0d first", i), 32'(out_log[i][0]), 32'({8'h11, 1'b1, 1'b0}));
                check($sformatf("t5 i%0d second", i), 32'(out_log[i][1]), 32'({8'h22, 1'b1, 1'b1}));
            end
        end

        // Asynchronous reset with three beats buffered and tvalid high
        m_tready = 1'b0;
        clear_logs();
        send(8'h61, 1'b1, tw);
        send(8'h62, 1'b1, tw);
        send(8'h63, 1'b1, tw);
        check("t6 valid before reset", 32'(o_tvalid[0]), 32'(1));
        #2 arstn = 1'b0;
        #1;
        check_all_zero("t6 async reset");
        @(posedge aclk);
        #3 arstn = 1'b1;
        @(posedge aclk);
        #1;
        m_tready = 1'b1;
        idle(30);
        check("t6 no stale beats i0", 32'(out_log[0].size()), 32'(0));
        check("t6 no stale beats i1", 32'(out_log[1].size()), 32'(0));
        check("t6 idle tvalid", 32'(o_tvalid[0]), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ft245_rx_packetizer.md
Name: ft245_rx_packetizer

Overview:
- Sits directly downstream of the FT245 sync-to-AXIS converter's master (receive) port.
- Buffers received beats in a small FIFO with skid headroom. The converter keeps presenting data for a few cycles after ready drops; the headroom absorbs those beats.
- Drops empty beats (tkeep all zero) and adds tlast framing. A packet ends on an idle timeout or on a maximum beat count.
- Output is a packetized AXIS stream for DMA or a framer.

Parameters:
- bus_width, 1, data width in bytes; tdata is bus_width*8 bits, tkeep is bus_width bits.
- fifo_depth, 16, FIFO entries; power of two, at least 4.
- skid_depth, 4, free entries reserved after s_axis_tready deasserts; must be less than fifo_depth.
- idle_timeout, 8, cycles with no new input before the held beat is released with tlast; must be at least 1.
- max_packet, 256, maximum beats per packet; must be at least 1.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- arstn  in  1  asynchronous active-low reset.
- s_axis_tdata  in  bus_width*8  data from the FT245 converter.
- s_axis_tkeep  in  bus_width  byte enables.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input ready; headroom request only.
- m_axis_tdata  out  bus_width*8  output data.
- m_axis_tkeep  out  bus_width  output byte enables.
- m_axis_tvalid  out  1  output valid.
- m_axis_tlast  out  1  last beat of packet.
- m_axis_tready  in  1  downstream ready.
- overflow  out  1  sticky flag: a beat was lost because the FIFO was full.

Behaviour:
- Reset (arstn low, asynchronous):
  - All counts, flags and pointers clear.
  - s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tkeep=0, overflow=0.
  - Reset taken mid-packet discards all buffered data; no partial packet is emitted afterwards.
- Input acceptance:
  - A write occurs when s_axis_tvalid=1, s_axis_tkeep is nonzero and the FIFO is not full. A write does not depend on s_axis_tready.
  - A beat with tkeep all zero is discarded silently and does not reset the idle counter.
  - s_axis_tvalid=1 with nonzero tkeep while the FIFO is full: the beat is dropped and overflow sets to 1. overflow stays set until reset.
  - s_axis_tready = 1 when count < fifo_depth - skid_depth. It is registered from count, so it has one cycle of lag.
- FIFO:
  - count ranges from 0 to fifo_depth. Pointers wrap modulo fifo_depth.
  - A simultaneous read and write leaves count unchanged, including at count = fifo_depth.
- Hold stage (register H with an H_valid bit):
  - H loads the FIFO head on the clock edge when the FIFO is non-empty and either H is empty or H is completing an output handshake that cycle.
  - Latency: input beat at edge t is in the FIFO after t, in H after t+1. It is eligible for release once a successor beat exists or the timeout fires.
- Idle counter:
  - Clears on any write.
  - Increments, saturating at idle_timeout, while H_valid=1, the FIFO is empty and no write occurs.
- Beat counter: counts completed handshakes in the current packet; clears after a handshake with tlast=1.
- Release (m_axis_tvalid rises) happens when H_valid=1 and at least one of:
  - (a) FIFO non-empty: tlast=0, unless beat counter = max_packet-1, in which case tlast=1.
  - (b) idle counter = idle_timeout: tlast=1.
  - (c) beat counter = max_packet-1: tlast=1.
- Output stability:
  - tlast is latched at release. tvalid, tdata, tkeep and tlast hold until m_axis_tready=1.
  - A write arriving after a timeout release does not clear tlast.
- Handshake with FIFO non-empty: H reloads the same cycle, giving back-to-back beats at full rate.
- Handshake with FIFO empty: H_valid=0 and m_axis_tvalid=0 the following cycle.

Test Plan:
- Single beat, no follow-up: tdata=0xA5, tkeep=1, then idle → m_axis_tvalid rises 8 cycles after the beat reaches H, tlast=1, tdata=0xA5; overflow=0.
- Burst of 5 consecutive beats 0x01..0x05 with m_axis_tready=1, then idle → 0x01..0x04 emitted with tlast=0; 0x05 emitted after the timeout with tlast=1.
- Stall downstream (m_axis_tready=0) while streaming → s_axis_tready drops when count reaches 12. Then push 4 more beats: all accepted, overflow stays 0, count=16. A 5th beat sets overflow=1 and is absent from the output.
- max_packet=4 (override), 10 continuous beats → tlast=1 on output beats 4 and 8; beats 9–10 close on timeout with tlast on beat 10.
- Beats with tkeep=0 interleaved with valid beats 0x11, 0x22 → only 0x11, 0x22 appear; the zero-keep beats do not restart the idle timeout.
- Assert arstn low with 3 beats buffered and m_axis_tvalid=1 → all outputs 0 immediately (asynchronously). After release, no stale beat is emitted and count=0.
